// File: rtl/motor_pkg.sv
// Shared types and bridge codes for the ramped motor driver.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        REV  = 2'd2,
        DEAD = 2'd3
    } ch_state_t;

    localparam logic [1:0] AB_FWD   = 2'b10;
    localparam logic [1:0] AB_REV   = 2'b01;
    localparam logic [1:0] AB_COAST = 2'b00;

    function automatic logic [1:0] dir_code(input logic fwd);
        return fwd ? AB_FWD : AB_REV;
    endfunction

endpackage

// File: rtl/motor_ramp_ch.sv
// One motor channel: direction FSM, duty ramp, reversal dead time and PWM compare.
module motor_ramp_ch
    import motor_pkg::*;
#(
    parameter int PWM_W    = 10,
    parameter int STEP     = 16,
    parameter int DEAD_PER = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             estop,
    input  logic             period_end,
    input  logic             ramp_tick,
    input  logic [PWM_W-1:0] pwm_cnt,
    input  logic             en,
    input  logic             dir,
    input  logic [PWM_W-1:0] speed,
    output logic             pwm,
    output logic [1:0]       in_ab,
    output logic             at_speed,
    output logic             busy
);

    localparam int DW = (DEAD_PER > 1) ? $clog2(DEAD_PER) : 1;
    localparam logic [PWM_W:0] STEP_X = (PWM_W+1)'(STEP);

    ch_state_t        state_reg, state_next;
    logic [PWM_W-1:0] cur_reg, cur_next;
    logic [PWM_W-1:0] duty_reg;
    logic [DW-1:0]    dead_reg, dead_next;
    logic             dir_lat_reg, dir_lat_next;
    logic             pwm_reg, at_speed_reg, busy_reg;
    logic [1:0]       in_ab_reg;
    logic [PWM_W-1:0] tgt;

    // One extra bit keeps cur+STEP and tgt+STEP from wrapping.
    function automatic logic [PWM_W-1:0] ramp_to(input logic [PWM_W-1:0] c,
                                                  input logic [PWM_W-1:0] t);
        logic [PWM_W:0] cx;
        logic [PWM_W:0] tx;
        cx = {1'b0, c};
        tx = {1'b0, t};
        if (cx < tx)
            ramp_to = ((cx + STEP_X) >= tx) ? t : PWM_W'(cx + STEP_X);
        else if (cx > tx)
            ramp_to = (cx < (tx + STEP_X)) ? t : PWM_W'(cx - STEP_X);
        else
            ramp_to = c;
    endfunction

    assign tgt = (en && !estop) ? speed : '0;

    always_comb begin
        state_next   = state_reg;
        cur_next     = cur_reg;
        dead_next    = dead_reg;
        dir_lat_next = dir_lat_reg;
        if (estop) begin
            state_next = IDLE;
            cur_next   = '0;
            dead_next  = '0;
        end else begin
            case (state_reg)
                IDLE: if (ramp_tick && tgt != '0) begin
                    if (dir == dir_lat_reg) begin
                        state_next = RUN;
                        cur_next   = ramp_to(cur_reg, tgt);
                    end else begin
                        state_next = DEAD;
                        dead_next  = '0;
                    end
                end
                RUN: if (ramp_tick) begin
                    if (dir != dir_lat_reg) begin
                        state_next = REV;
                        cur_next   = ramp_to(cur_reg, '0);
                    end else begin
                        cur_next = ramp_to(cur_reg, tgt);
                        if (cur_next == '0 && tgt == '0)
                            state_next = IDLE;
                    end
                end
                REV: if (ramp_tick) begin
                    if (cur_reg == '0) begin
                        state_next = DEAD;
                        dead_next  = '0;
                    end else begin
                        cur_next = ramp_to(cur_reg, '0);
                    end
                end
                DEAD: if (period_end) begin
                    if (dead_reg == DW'(DEAD_PER - 1)) begin
                        // Direction is latched only once the bridge has coasted.
                        dir_lat_next = dir;
                        dead_next    = '0;
                        if (tgt != '0) begin
                            state_next = RUN;
                            if (ramp_tick)
                                cur_next = ramp_to(cur_reg, tgt);
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        dead_next = dead_reg + DW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cur_reg      <= '0;
            duty_reg     <= '0;
            dead_reg     <= '0;
            dir_lat_reg  <= 1'b1;
            pwm_reg      <= 1'b0;
            in_ab_reg    <= AB_COAST;
            at_speed_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cur_reg     <= cur_next;
            dead_reg    <= dead_next;
            dir_lat_reg <= dir_lat_next;
            if (estop)
                duty_reg <= '0;
            else if (period_end)
                duty_reg <= cur_next;
            pwm_reg      <= !estop && (pwm_cnt < duty_reg);
            in_ab_reg    <= (state_next == RUN || state_next == REV) ?
                            dir_code(dir_lat_next) : AB_COAST;
            at_speed_reg <= (cur_next == tgt) && (state_next == RUN || state_next == IDLE);
            busy_reg     <= (state_next == REV) || (state_next == DEAD) ||
                            (state_next == RUN && cur_next != tgt);
        end
    end

    assign pwm      = pwm_reg;
    assign in_ab    = in_ab_reg;
    assign at_speed = at_speed_reg;
    assign busy     = busy_reg;

endmodule

// File: rtl/motor_ramp_driver.sv
// N-channel DC-motor driver: shared PWM timebase feeding independent ramped channels.
module motor_ramp_driver
    import motor_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int PWM_W    = 10,
    parameter int PRESC    = 1,
    parameter int RAMP_DIV = 4,
    parameter int STEP     = 16,
    parameter int DEAD_PER = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  estop,
    input  logic [N_CH-1:0]       en,
    input  logic [N_CH-1:0]       dir,
    input  logic [N_CH*PWM_W-1:0] speed,
    output logic [N_CH-1:0]       pwm,
    output logic [2*N_CH-1:0]     in_ab,
    output logic [N_CH-1:0]       at_speed,
    output logic [N_CH-1:0]       busy
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int RW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PW-1:0]    presc_reg;
    logic [PWM_W-1:0] pwm_cnt_reg;
    logic [RW-1:0]    ramp_cnt_reg;
    logic             tick, period_end, ramp_tick;

    assign tick       = (presc_reg == PW'(PRESC - 1));
    assign period_end = tick && (pwm_cnt_reg == '1);
    assign ramp_tick  = period_end && (ramp_cnt_reg == RW'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg    <= '0;
            pwm_cnt_reg  <= '0;
            ramp_cnt_reg <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + PW'(1);
            if (tick)
                pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
            if (period_end)
                ramp_cnt_reg <= (ramp_cnt_reg == RW'(RAMP_DIV - 1)) ? '0 : ramp_cnt_reg + RW'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            motor_ramp_ch #(
                .PWM_W    (PWM_W),
                .STEP     (STEP),
                .DEAD_PER (DEAD_PER)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .estop      (estop),
                .period_end (period_end),
                .ramp_tick  (ramp_tick),
                .pwm_cnt    (pwm_cnt_reg),
                .en         (en[gi]),
                .dir        (dir[gi]),
                .speed      (speed[gi*PWM_W +: PWM_W]),
                .pwm        (pwm[gi]),
                .in_ab      (in_ab[2*gi +: 2]),
                .at_speed   (at_speed[gi]),
                .busy       (busy[gi])
            );
        end
    endgenerate

endmodule
